// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 8-bit LFSR pattern generator (x^8+x^6+x^5+x^4+1).
// Seeds a reference LFSR from the incoming stream, then counts mismatches and tracks lock.
module lfsr_stream_checker #(
    parameter int CNT_W   = 16,
    parameter int WIN     = 32,
    parameter int LOSS_TH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             syncInit,
    input  logic             sin,
    input  logic             sinValid,
    output logic             locked,
    output logic             errPulse,
    output logic [CNT_W-1:0] errCount,
    output logic [CNT_W-1:0] bitCount
);

    localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int ERR_W = $clog2(LOSS_TH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t           state, stateNext;
    logic [7:0]       h, hNext;
    logic [2:0]       seedCnt, seedCntNext;
    logic [WIN_W-1:0] winCnt, winCntNext;
    logic [ERR_W-1:0] winErr, winErrNext, winErrInc;
    logic [CNT_W-1:0] errCountNext, bitCountNext;
    logic             errPulseNext;
    logic             predicted, mismatch;
    logic [7:0]       seedShift;

    assign predicted = h[7] ^ h[5] ^ h[4] ^ h[3];
    assign mismatch  = sin ^ predicted;
    assign seedShift = {h[6:0], sin};
    assign winErrInc = winErr + ERR_W'(mismatch);

    // Valid/ready: there is no back-pressure; a bit is consumed on every rising
    // edge where sinValid is high, and nothing changes on edges where it is low.
    always_comb begin
        stateNext    = state;
        hNext        = h;
        seedCntNext  = seedCnt;
        winCntNext   = winCnt;
        winErrNext   = winErr;
        errCountNext = errCount;
        bitCountNext = bitCount;
        errPulseNext = 1'b0;

        if (syncInit) begin
            stateNext    = SEED;
            hNext        = '0;
            seedCntNext  = '0;
            winCntNext   = '0;
            winErrNext   = '0;
            errCountNext = '0;
            bitCountNext = '0;
        end else if (sinValid) begin
            case (state)
                SEED: begin
                    hNext = seedShift;
                    if (seedCnt == 3'd7) begin
                        seedCntNext = '0;
                        // An all-zero history would lock the LFSR up; gather a fresh seed.
                        if (seedShift != 8'd0) begin
                            stateNext = CHECK;
                        end
                    end else begin
                        seedCntNext = seedCnt + 3'd1;
                    end
                end
                CHECK: begin
                    // The prediction, not the received bit, advances the reference so a
                    // line error stays a single error.
                    hNext = {h[6:0], predicted};
                    if (bitCount != CNT_MAX) begin
                        bitCountNext = bitCount + CNT_W'(1);
                    end
                    if (mismatch) begin
                        errPulseNext = 1'b1;
                        if (errCount != CNT_MAX) begin
                            errCountNext = errCount + CNT_W'(1);
                        end
                    end
                    if (mismatch && (winErrInc == ERR_W'(LOSS_TH))) begin
                        stateNext   = SEED;
                        seedCntNext = '0;
                        winCntNext  = '0;
                        winErrNext  = '0;
                    end else if (winCnt == WIN_W'(WIN - 1)) begin
                        winCntNext = '0;
                        winErrNext = '0;
                    end else begin
                        winCntNext = winCnt + WIN_W'(1);
                        winErrNext = winErrInc;
                    end
                end
                default: begin
                    stateNext = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEED;
            h        <= '0;
            seedCnt  <= '0;
            winCnt   <= '0;
            winErr   <= '0;
            errCount <= '0;
            bitCount <= '0;
            errPulse <= 1'b0;
        end else begin
            state    <= stateNext;
            h        <= hNext;
            seedCnt  <= seedCntNext;
            winCnt   <= winCntNext;
            winErr   <= winErrNext;
            errCount <= errCountNext;
            bitCount <= bitCountNext;
            errPulse <= errPulseNext;
        end
    end

    assign locked = (state == CHECK);

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: a sequence-level reference model checked every cycle
// against a default-width instance and a 4-bit-counter instance fed the same stream.
module tb_lfsr_stream_checker;

    localparam int CNT_W   = 16;
    localparam int SMALL_W = 4;
    localparam int WIN     = 32;
    localparam int LOSS_TH = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic syncInit = 1'b0;
    logic sin = 1'b0;
    logic sinValid = 1'b0;
    always #5 clk = ~clk;

    logic             locked, errPulse;
    logic [CNT_W-1:0] errCount, bitCount;
    logic               locked4, errPulse4;
    logic [SMALL_W-1:0] errCount4, bitCount4;

    lfsr_stream_checker #(.CNT_W(CNT_W), .WIN(WIN), .LOSS_TH(LOSS_TH)) dut (
        .clk(clk), .reset(reset), .syncInit(syncInit), .sin(sin), .sinValid(sinValid),
        .locked(locked), .errPulse(errPulse), .errCount(errCount), .bitCount(bitCount)
    );

    lfsr_stream_checker #(.CNT_W(SMALL_W), .WIN(WIN), .LOSS_TH(LOSS_TH)) dut4 (
        .clk(clk), .reset(reset), .syncInit(syncInit), .sin(sin), .sinValid(sinValid),
        .locked(locked4), .errPulse(errPulse4), .errCount(errCount4), .bitCount(bitCount4)
    );

    int checks = 0;
    int failures = 0;
    int pulse_seen = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: works on the bit sequence, s[n] = s[n-8]^s[n-6]^s[n-5]^s[n-4]
    bit m_locked = 1'b0;
    bit m_pulse = 1'b0;
    bit m_seed[$];
    bit m_ref[$];
    int m_err = 0;
    int m_bits = 0;
    int m_since = 0;
    int m_blk = 0;

    function automatic void model_clear();
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        m_seed.delete();
        m_ref.delete();
        m_err   = 0;
        m_bits  = 0;
        m_since = 0;
        m_blk   = 0;
    endfunction

    function automatic void model_accept(bit b);
        bit pred;
        int ones;
        if (!m_locked) begin
            m_seed.push_back(b);
            if (m_seed.size() == 8) begin
                ones = 0;
                foreach (m_seed[i]) ones += int'(m_seed[i]);
                if (ones != 0) begin
                    m_ref    = m_seed;
                    m_locked = 1'b1;
                    m_since  = 0;
                    m_blk    = 0;
                end
                m_seed.delete();
            end
        end else begin
            pred = m_ref[0] ^ m_ref[2] ^ m_ref[3] ^ m_ref[4];
            void'(m_ref.pop_front());
            m_ref.push_back(pred);
            m_bits++;
            if (m_since % WIN == 0) m_blk = 0;
            m_since++;
            if (b != pred) begin
                m_err++;
                m_pulse = 1'b1;
                m_blk++;
                if (m_blk == LOSS_TH) m_locked = 1'b0;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_clear();
        end else begin
            m_pulse = 1'b0;
            if (syncInit) model_clear();
            else if (sinValid) model_accept(sin);
        end
    end

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // scoreboard: every cycle, both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked", locked, m_locked);
            check("errPulse", errPulse, m_pulse);
            check("errCount", errCount, sat(m_err, CNT_W));
            check("bitCount", bitCount, sat(m_bits, CNT_W));
            check("locked4", locked4, m_locked);
            check("errPulse4", errPulse4, m_pulse);
            check("errCount4", errCount4, sat(m_err, SMALL_W));
            check("bitCount4", bitCount4, sat(m_bits, SMALL_W));
            pulse_seen += int'(errPulse);
        end
    end

    // generator model: shift left, feedback q7^q5^q4^q3 into q0, output q7
    bit [7:0] g;
    function automatic bit gen_bit();
        bit b;
        b = g[7];
        g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
        return b;
    endfunction

    // driver: present inputs for one edge, return at the following negedge
    task automatic step(input bit v, input bit b, input bit si);
        sinValid = v;
        sin      = b;
        syncInit = si;
        @(negedge clk);
    endtask

    initial begin
        bit b;
        bit v;

        repeat (2) @(negedge clk);
        check("reset_locked", locked, 0);
        check("reset_errPulse", errPulse, 0);
        check("reset_errCount", errCount, 0);
        check("reset_bitCount", bitCount, 0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // clean stream from seed 8'h01
        step(0, 0, 1);
        g = 8'h01;
        pulse_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1, gen_bit(), 0);
            if (i == 7) check("clean_locked_bit7", locked, 0);
            if (i == 8) check("clean_locked_bit8", locked, 1);
        end
        step(0, 0, 0);
        check("clean_errCount", errCount, 0);
        check("clean_bitCount", bitCount, 32);
        check("clean_bitCount4_sat", bitCount4, 15);
        check("clean_pulses", pulse_seen, 0);

        // single inverted bit 20
        step(0, 0, 1);
        g = 8'h01;
        pulse_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            b = gen_bit();
            if (i == 20) b = ~b;
            step(1, b, 0);
            if (i == 20) check("inv20_pulse", errPulse, 1);
            if (i == 21) check("inv20_pulse_gone", errPulse, 0);
        end
        step(0, 0, 0);
        check("inv20_errCount", errCount, 1);
        check("inv20_locked", locked, 1);
        check("inv20_pulses", pulse_seen, 1);
        check("inv20_bitCount", bitCount, 32);

        // lock-up seed of eight zeros
        step(0, 0, 1);
        repeat (8) step(1, 0, 0);
        check("zeros_locked", locked, 0);
        g = 8'h01;
        for (int i = 1; i <= 40; i++) begin
            step(1, gen_bit(), 0);
            if (i == 7) check("zeros_locked_bit7", locked, 0);
            if (i == 8) check("zeros_locked_bit8", locked, 1);
        end
        check("zeros_bitCount", bitCount, 32);

        // loss of lock after four errors, then re-lock
        step(0, 0, 1);
        g = 8'h01;
        repeat (20) step(1, gen_bit(), 0);
        for (int i = 1; i <= 4; i++) begin
            step(1, ~gen_bit(), 0);
            if (i == 3) check("loss_locked_err3", locked, 1);
        end
        check("loss_locked", locked, 0);
        check("loss_errCount", errCount, 4);
        check("loss_bitCount", bitCount, 16);
        for (int i = 1; i <= 8; i++) begin
            step(1, gen_bit(), 0);
            if (i == 7) check("relock_bit7", locked, 0);
        end
        check("relock_locked", locked, 1);
        check("relock_bitCount", bitCount, 16);
        repeat (8) step(1, gen_bit(), 0);
        check("relock_bitCount_after", bitCount, 24);
        check("relock_errCount_after", errCount, 4);

        // sinValid toggling
        step(0, 0, 1);
        g = 8'h01;
        for (int i = 1; i <= 40; i++) begin
            step(1, gen_bit(), 0);
            step(0, 1'($urandom_range(0, 1)), 0);
        end
        check("toggle_errCount", errCount, 0);
        check("toggle_bitCount", bitCount, 32);
        check("toggle_locked", locked, 1);

        // randomized stream with injected errors and a burst of noise
        step(0, 0, 1);
        g = 8'h01;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if (n >= 600 && n < 700) b = 1'($urandom_range(0, 1));
            else if (v) b = gen_bit() ^ ($urandom_range(0, 15) == 0);
            else b = 1'($urandom_range(0, 1));
            step(v, b, 0);
        end
        check("sat_errCount4", errCount4, 15);
        check("sat_bitCount4", bitCount4, 15);

        // syncInit together with sinValid clears everything
        step(1, 1, 1);
        check("sync_locked", locked, 0);
        check("sync_errCount", errCount, 0);
        check("sync_bitCount", bitCount, 0);
        check("sync_errCount4", errCount4, 0);

        // random stream with occasional syncInit
        g = 8'h01;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 2) != 0);
            b = v ? (gen_bit() ^ ($urandom_range(0, 31) == 0)) : 1'b0;
            step(v, b, ($urandom_range(0, 99) == 0));
        end

        // asynchronous reset in the middle of a cycle
        step(0, 0, 1);
        g = 8'h01;
        repeat (20) step(1, gen_bit(), 0);
        step(0, 0, 0);
        check("pre_reset_bitCount", bitCount, 12);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_locked", locked, 0);
        check("async_bitCount", bitCount, 0);
        check("async_errCount", errCount, 0);
        check("async_errPulse", errPulse, 0);
        @(negedge clk);
        reset = 1'b0;
        g = 8'h01;
        repeat (10) step(1, gen_bit(), 0);
        check("post_reset_locked", locked, 1);
        check("post_reset_bitCount", bitCount, 2);

        step(0, 0, 0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive end of the team's 8-bit LFSR pattern generator: consumes the generator's serial output stream, one bit per accepted cycle.
- Self-seeds an internal reference LFSR from the incoming bits, then predicts each following bit and compares it with the received bit.
- Reports lock status, per-bit error pulses and saturating error/bit counts.
- Used as the on-chip pattern checker for link and loopback tests.

Parameters:
- CNT_W, 16, width of errCount and bitCount.
- WIN, 32, loss-of-lock observation window in accepted bits.
- LOSS_TH, 4, number of errors within one window that forces re-seeding.

Ports:
- clk  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- syncInit  in  1  synchronous clear: restart seeding and zero all counters.
- sin  in  1  received serial bit.
- sinValid  in  1  sin is sampled on the rising edge only when this is 1.
- locked  out  1  checker is in CHECK state.
- errPulse  out  1  registered; 1 for exactly one cycle after a mismatching bit is accepted in CHECK.
- errCount  out  CNT_W  errors since the last clear, saturating at all-ones.
- bitCount  out  CNT_W  bits compared in CHECK since the last clear, saturating at all-ones.

Behaviour:
- Polynomial: x^8+x^6+x^5+x^4+1, matching the generator. The generator shifts left, feeds back q7^q5^q4^q3 into q0, and serial bit = q7.
- Checker history h[7:0]: h[0] is the newest bit. Predicted next bit p = h7^h5^h4^h3.
- Reset (async) and syncInit (sync, takes priority over sinValid) both force: state=SEED, seedCnt=0, h=0, winCnt=0, winErr=0, errCount=0, bitCount=0, locked=0, errPulse=0.
- No state changes on cycles where sinValid=0. errPulse is 0 on those cycles.
- SEED state:
  - Each accepted bit: h <= {h[6:0],sin}; seedCnt++.
  - On the 8th accepted bit: if the resulting h == 0 (lock-up pattern), seedCnt <= 0 and stay in SEED. Otherwise go to CHECK.
  - locked=1 from the next edge onward. Latency from the 8th seed bit to locked=1 is 1 clk.
- CHECK state, on each accepted bit:
  - Compare sin with p. Shift the predicted bit p into h, not sin, so a single line error does not corrupt later predictions.
  - bitCount++ (saturating).
  - On mismatch: errPulse=1 next cycle, errCount++ (saturating), winErr++.
  - winCnt++. When winCnt reaches WIN-1 on an accepted bit, winCnt and winErr return to 0 on the next edge.
- Loss of lock:
  - If a mismatch makes winErr reach LOSS_TH, go to SEED with seedCnt=0, winCnt=0, winErr=0; locked=0 next cycle.
  - errCount and bitCount are kept, not cleared.
  - The mismatching bit is counted and is not used as a seed bit.
- Saturation: at all-ones, errCount and bitCount hold, with no wrap-around.
- syncInit asserted together with sinValid: the bit is discarded and the clear wins.
- Reset mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.

Test Plan:
- Generator seeded with 8'h01, 40 valid bits streamed in → locked=1 one clk after the 8th bit; errCount=0 and bitCount=32 at the end; errPulse never asserted.
- Same stream with bit 20 inverted → one errPulse, one clk after bit 20 is accepted; errCount=1; locked stays 1; subsequent bits produce no further errors (no error propagation).
- 8 zero bits, then the correct stream → still SEED after the 8 zeros (locked=0); locks 8 valid bits later.
- Locked, then 4 inverted bits within 32 → locked=0 one clk after the 4th error; errCount=4; re-locks after 8 more clean bits; bitCount is not cleared.
- sinValid toggled 1/0 every cycle over the correct stream → identical counts to the continuous case; no state change on idle cycles.
- Error count near saturation (CNT_W=4, forced errors beyond 15) → errCount holds at 15. Then syncInit pulse → all counters 0 and locked=0 on the next edge. Async reset asserted mid-cycle → outputs 0 immediately.
